// File: rtl/metro_fare_arbiter.sv
// Round-robin arbiter that shares one fare checker between several turnstile
// lanes. A granted lane's code and balance are latched and offered to the
// checker. The result, or a timeout verdict, is strobed back to that lane.
module metro_fare_arbiter #(
  parameter int LANES      = 4,
  parameter int CODE_BITS  = 6,
  parameter int MONEY_BITS = 14,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ena,
  input  logic [LANES-1:0]            req,
  input  logic [LANES*CODE_BITS-1:0]  lane_code,
  input  logic [LANES*MONEY_BITS-1:0] lane_balance,
  output logic                        chk_valid,
  output logic [CODE_BITS-1:0]        chk_code,
  output logic [MONEY_BITS-1:0]       chk_balance,
  input  logic                        chk_ready,
  input  logic                        chk_done,
  input  logic                        chk_ok,
  input  logic [MONEY_BITS-1:0]       chk_new_balance,
  output logic [LANES-1:0]            grant,
  output logic [LANES-1:0]            lane_done,
  output logic                        lane_ok,
  output logic [MONEY_BITS-1:0]       lane_new_balance,
  output logic                        busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPLY} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         idx_nxt;
  logic [IW-1:0]         pick;
  logic                  found;
  int                    cand;
  logic [7:0]            cnt;
  logic [8:0]            cnt_inc;
  logic                  timeout;
  logic                  res_ok;
  logic [MONEY_BITS-1:0] res_bal;
  logic                  suppress;

  function automatic logic [IW-1:0] next_lane(input logic [IW-1:0] i);
    if (int'(i) == LANES - 1) return '0;
    else return i + IW'(1);
  endfunction

  function automatic logic [LANES-1:0] onehot(input logic [IW-1:0] i);
    logic [LANES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requesting lane at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < LANES; i++) begin
      cand = (int'(rr_ptr) + i) % LANES;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end else begin
        found = found;
      end
    end
  end

  // Next-state logic; a checker result beats a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    cnt_inc   = {1'b0, cnt} + 9'd1;
    timeout   = (cnt_inc >= 9'(TIMEOUT));
    case (state)
      IDLE:    if (found) state_nxt = ISSUE; else state_nxt = IDLE;
      ISSUE: begin
        if (chk_ready)          state_nxt = WAIT;
        else if (!req[gnt_idx]) state_nxt = IDLE;
        else                    state_nxt = ISSUE;
      end
      WAIT:    if (chk_done || timeout) state_nxt = REPLY; else state_nxt = WAIT;
      REPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == IDLE) idx_nxt = pick;
    else               idx_nxt = gnt_idx;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  // Datapath: latching, timeout counter, pointer, result and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr           <= '0;
      gnt_idx          <= '0;
      cnt              <= 8'd0;
      res_ok           <= 1'b0;
      res_bal          <= '0;
      suppress         <= 1'b0;
      chk_code         <= '0;
      chk_balance      <= '0;
      chk_valid        <= 1'b0;
      grant            <= '0;
      busy             <= 1'b0;
      lane_done        <= '0;
      lane_ok          <= 1'b0;
      lane_new_balance <= '0;
    end else if (ena) begin
      lane_done <= '0;
      lane_ok   <= 1'b0;
      chk_valid <= (state_nxt == ISSUE);
      busy      <= (state_nxt != IDLE);
      grant     <= (state_nxt == IDLE) ? '0 : onehot(idx_nxt);
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx     <= pick;
            chk_code    <= lane_code[int'(pick)*CODE_BITS +: CODE_BITS];
            chk_balance <= lane_balance[int'(pick)*MONEY_BITS +: MONEY_BITS];
            suppress    <= 1'b0;
          end
        end
        ISSUE: begin
          if (chk_ready) begin
            cnt <= 8'd0;
            if (!req[gnt_idx]) suppress <= 1'b1;
          end else if (!req[gnt_idx]) begin
            rr_ptr <= next_lane(gnt_idx);
          end
        end
        WAIT: begin
          cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          if (!req[gnt_idx]) suppress <= 1'b1;
          if (chk_done) begin
            res_ok  <= chk_ok;
            res_bal <= chk_new_balance;
          end else if (timeout) begin
            res_ok  <= 1'b0;
            res_bal <= chk_balance;
          end
        end
        REPLY: begin
          rr_ptr <= next_lane(gnt_idx);
          if (!suppress && req[gnt_idx]) begin
            lane_done        <= onehot(gnt_idx);
            lane_ok          <= res_ok;
            lane_new_balance <= res_bal;
          end
        end
        default: begin
          rr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/metro_fare_arbiter.md
METRO_FARE_ARBITER -- requirements
Module: metro_fare_arbiter

Parameters
REQ-001 SHALL have parameter LANES, default 4: number of turnstile lanes sharing one fare checker.
REQ-002 SHALL have parameter CODE_BITS, default 6: card code width.
REQ-003 SHALL have parameter MONEY_BITS, default 14: balance width.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum enabled cycles to wait for the checker result; legal range 1..255.

Interface
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ena  in  1  clock enable; when low, all state, counters and the pointer SHALL hold.
REQ-008 req  in  LANES  per-lane card-attached request, level.
REQ-009 lane_code  in  LANES*CODE_BITS  per-lane card code; lane k occupies bits [k*CODE_BITS +: CODE_BITS].
REQ-010 lane_balance  in  LANES*MONEY_BITS  per-lane card balance, packed the same way.
REQ-011 chk_valid  out  1  request to the shared checker.
REQ-012 chk_code  out  CODE_BITS  code of the granted lane.
REQ-013 chk_balance  out  MONEY_BITS  balance of the granted lane.
REQ-014 chk_ready  in  1  checker accepts the request.
REQ-015 chk_done  in  1  one-cycle result strobe from the checker.
REQ-016 chk_ok  in  1  fare accepted; valid with chk_done.
REQ-017 chk_new_balance  in  MONEY_BITS  balance after deduction; valid with chk_done.
REQ-018 grant  out  LANES  one-hot grant of the lane being served; zero in IDLE.
REQ-019 lane_done  out  LANES  one-cycle, one-hot result strobe to the served lane.
REQ-020 lane_ok  out  1  result for the lane strobed by lane_done.
REQ-021 lane_new_balance  out  MONEY_BITS  balance to display; valid with lane_done.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 SHALL implement an FSM with the states IDLE, ISSUE, WAIT and REPLY.
REQ-024 IDLE: if any req bit is set, the FSM SHALL select the first set lane at or after rr_ptr, wrapping round-robin, latch its index and go to ISSUE on the next edge; otherwise it stays in IDLE.
REQ-025 ISSUE: grant and chk_valid SHALL be high, and chk_code and chk_balance SHALL be registered copies of the granted lane's inputs, latched on IDLE exit and held stable.
REQ-026 ISSUE: chk_valid AND chk_ready SHALL move the FSM to WAIT and clear the timeout counter.
REQ-027 ISSUE: if the granted lane's req drops before the handshake, the FSM SHALL return to IDLE with no lane_done, and rr_ptr SHALL advance to the granted lane + 1.
REQ-028 WAIT: chk_valid SHALL be low, and the counter SHALL increment on each enabled cycle.
REQ-029 WAIT: chk_done SHALL capture chk_ok and chk_new_balance and move the FSM to REPLY.
REQ-030 WAIT: when the counter reaches TIMEOUT without chk_done, the FSM SHALL go to REPLY with ok=0 and new_balance equal to the latched chk_balance.
REQ-031 WAIT: if chk_done and timeout occur in the same cycle, chk_done SHALL win.
REQ-032 WAIT: if the granted lane drops req, the FSM SHALL still wait for completion, but the lane_done strobe for that transaction SHALL be suppressed.
REQ-033 REPLY: lane_done[granted] SHALL pulse for exactly one cycle together with lane_ok and lane_new_balance.
REQ-034 REPLY: rr_ptr SHALL become the granted lane + 1 mod LANES, and the FSM SHALL return to IDLE.
REQ-035 Request-to-issue latency SHALL be 1 cycle, and the minimum request-to-lane_done latency SHALL be 4 cycles (chk_ready and chk_done each arriving in the first possible cycle).
REQ-036 The lane that was just served SHALL hold the lowest priority in the next arbitration, so no lane starves while the others keep requesting.
REQ-037 chk_done while in IDLE, ISSUE or REPLY SHALL be ignored.
REQ-038 The timeout counter SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-039 reset high SHALL asynchronously force state=IDLE, rr_ptr=0, counter=0, grant=0, chk_valid=0, lane_done=0, lane_ok=0, busy=0, and chk_code, chk_balance and lane_new_balance to 0.
REQ-040 reset asserted mid-transaction SHALL abandon the transaction with no lane_done and no chk_valid on release; arbitration SHALL restart from lane 0.

Verification
REQ-041 Single request: req=4'b0100, balance 100, checker returns ok=1 and 55 two cycles after handshake -> lane_done=4'b0100 for one cycle, lane_ok=1, lane_new_balance=55.
REQ-042 Round-robin: req=4'b1111 held high, checker responds immediately -> grants occur in the order 0001, 0010, 0100, 1000, 0001.
REQ-043 Timeout: TIMEOUT=15 and chk_done never arrives -> lane_done is strobed 15 enabled cycles after entering WAIT, with lane_ok=0 and lane_new_balance equal to the input balance.
REQ-044 Withdrawal: req[1] drops in ISSUE before chk_ready -> back to IDLE, no lane_done, and the next grant goes to the next requesting lane after 1.
REQ-045 Collision and reset: chk_done arrives in the same cycle the counter hits TIMEOUT -> lane_ok equals chk_ok. reset pulsed in WAIT -> all outputs are 0 at once, and lane 0 is served first afterward.
REQ-046 ena held low for 5 cycles in WAIT -> state and counter are frozen, and the timeout strobe is delayed by exactly 5 cycles.
